// File: rtl/fib_seq_gen.sv
// Fibonacci generator: computes F(n) once or streams F(0)..F(n) over a valid/ready port.
// Optional macro FIB_OVF_SAT_EN makes overflowed terms saturate to all-ones instead of wrapping.
module fib_seq_gen #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [IDX_W-1:0] n,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             a_ovf_reg, a_ovf_next;
    logic             b_ovf_reg, b_ovf_next;
    logic [IDX_W-1:0] k_reg, k_next;
    logic [IDX_W-1:0] n_reg, n_next;
    logic             mode_reg, mode_next;

    logic [WIDTH:0]   sum;
    logic             sum_ovf;
    logic [WIDTH-1:0] b_step;
    logic             k_done;
    logic             beat_last;
    logic             advance;

    assign sum     = {1'b0, a_reg} + {1'b0, b_reg};
    assign sum_ovf = sum[WIDTH] | a_ovf_reg | b_ovf_reg;

`ifdef FIB_OVF_SAT_EN
    assign b_step = sum_ovf ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    assign b_step = sum[WIDTH-1:0];
`endif

    assign k_done    = (k_reg == n_reg);
    assign beat_last = !mode_reg || k_done;
    assign busy      = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        a_ovf_next = a_ovf_reg;
        b_ovf_next = b_ovf_reg;
        k_next     = k_reg;
        n_next     = n_reg;
        mode_next  = mode_reg;
        advance    = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        out_ovf    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = '0;
                    b_next     = WIDTH'(1);
                    a_ovf_next = 1'b0;
                    b_ovf_next = 1'b0;
                    k_next     = '0;
                    n_next     = n;
                    mode_next  = mode;
                    state_next = mode ? EMIT : CALC;
                end
            end
            CALC: begin
                if (k_done) begin
                    state_next = EMIT;
                end else begin
                    advance = 1'b1;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_data  = a_reg;
                out_ovf   = a_ovf_reg;
                out_last  = beat_last;
                if (out_ready) begin
                    if (beat_last) begin
                        state_next = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // k stops at n, so the increment can never wrap inside a job
        if (advance) begin
            a_next     = b_reg;
            a_ovf_next = b_ovf_reg;
            b_next     = b_step;
            b_ovf_next = sum_ovf;
            k_next     = k_reg + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= WIDTH'(1);
            a_ovf_reg <= 1'b0;
            b_ovf_reg <= 1'b0;
            k_reg     <= '0;
            n_reg     <= '0;
            mode_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            a_ovf_reg <= a_ovf_next;
            b_ovf_reg <= b_ovf_next;
            k_reg     <= k_next;
            n_reg     <= n_next;
            mode_reg  <= mode_next;
        end
    end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Self-checking bench for fib_seq_gen: a 32-bit and an 8-bit instance checked against
// an exact-arithmetic Fibonacci model with randomized jobs and backpressure.
module tb_fib_seq_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  n_in = '0;
    logic        ready = 1'b0;
    logic        sel8 = 1'b0;

    logic        busy32, v32, l32, o32;
    logic [31:0] d32;
    logic        busy8, v8, l8, o8;
    logic [7:0]  d8;

    logic        obs_busy, obs_valid, obs_last, obs_ovf;
    logic [31:0] obs_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fib_seq_gen #(.WIDTH(32), .IDX_W(8)) u32 (
        .clk(clk), .rst(rst), .start(start & ~sel8), .mode(mode), .n(n_in),
        .busy(busy32), .out_valid(v32), .out_ready(ready & ~sel8),
        .out_data(d32), .out_last(l32), .out_ovf(o32)
    );

    fib_seq_gen #(.WIDTH(8), .IDX_W(8)) u8 (
        .clk(clk), .rst(rst), .start(start & sel8), .mode(mode), .n(n_in),
        .busy(busy8), .out_valid(v8), .out_ready(ready & sel8),
        .out_data(d8), .out_last(l8), .out_ovf(o8)
    );

    assign obs_busy  = sel8 ? busy8 : busy32;
    assign obs_valid = sel8 ? v8 : v32;
    assign obs_last  = sel8 ? l8 : l32;
    assign obs_ovf   = sel8 ? o8 : o32;
    assign obs_data  = sel8 ? {24'd0, d8} : d32;

    // Exact Fibonacci value; valid for k <= 93
    function automatic longint unsigned fib(input int k);
        longint unsigned fa = 0, fb = 1, t;
        for (int i = 0; i < k; i++) begin
            t = fa + fb;
            fa = fb;
            fb = t;
        end
        return fa;
    endfunction

    function automatic logic [31:0] exp_data(input int k, input int w);
        longint unsigned f  = fib(k);
        longint unsigned mx = (w == 32) ? 64'hFFFF_FFFF : 64'hFF;
        if (f > mx) begin
`ifdef FIB_OVF_SAT_EN
            return 32'(mx);
`else
            return 32'(f & mx);
`endif
        end
        return 32'(f);
    endfunction

    function automatic logic exp_ovf(input int k, input int w);
        longint unsigned mx = (w == 32) ? 64'hFFFF_FFFF : 64'hFF;
        return fib(k) > mx;
    endfunction

    task automatic do_start(input logic m, input int nn);
        start = 1'b1;
        mode  = m;
        n_in  = 8'(nn);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        n_cmp++; if ({busy32, v32, l32, o32, d32} !== 36'd0) begin n_err++; $display("FAIL reset_state32: got %h want 0", {busy32, v32, l32, o32, d32}); end
        n_cmp++; if ({busy8, v8, l8, o8, d8} !== 12'd0) begin n_err++; $display("FAIL reset_state8: got %h want 0", {busy8, v8, l8, o8, d8}); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sel8 = 1'b0; ready = 1'b1;
        do_start(1'b1, 20);
        repeat (5) begin @(posedge clk); #1; end
        n_cmp++; if (obs_data !== 32'd5 || obs_valid !== 1'b1) begin n_err++; $display("FAIL reset_beat5: got v=%0b d=%0d want v=1 d=5", obs_valid, obs_data); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({obs_busy, obs_valid, obs_data} !== 34'd0) begin n_err++; $display("FAIL reset_async: got busy=%0b v=%0b d=%0d want 0", obs_busy, obs_valid, obs_data); end
        @(posedge clk); #1;
        n_cmp++; if ({obs_busy, obs_valid, obs_data} !== 34'd0) begin n_err++; $display("FAIL reset_next: got busy=%0b v=%0b d=%0d want 0", obs_busy, obs_valid, obs_data); end
        rst = 1'b0;
        @(posedge clk); #1;
        do_start(1'b1, 3);
        for (int i = 0; i <= 3; i++) begin
            n_cmp++; if (obs_valid !== 1'b1 || obs_data !== exp_data(i, 32) || obs_last !== (i == 3)) begin
                n_err++; $display("FAIL reset_restream[%0d]: got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b", i, obs_valid, obs_data, obs_last, exp_data(i, 32), i == 3);
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (obs_busy !== 1'b0) begin n_err++; $display("FAIL reset_restream_end: got busy=%0b want 0", obs_busy); end
        $display("reset test: stream abandoned at beat 5, restream n=3 done");
    endtask

    task automatic test_single_latency;
        int cnt = 0;
        sel8 = 1'b0; ready = 1'b1;
        do_start(1'b0, 10);
        while (!obs_valid && cnt < 50) begin @(posedge clk); #1; cnt++; end
        n_cmp++; if (cnt !== 11) begin n_err++; $display("FAIL single_latency: got %0d cycles want 11", cnt); end
        n_cmp++; if (obs_data !== 32'd55 || obs_last !== 1'b1 || obs_ovf !== 1'b0) begin
            n_err++; $display("FAIL single_value: got d=%0d l=%0b o=%0b want d=55 l=1 o=0", obs_data, obs_last, obs_ovf);
        end
        @(posedge clk); #1;
        n_cmp++; if (obs_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %0b want 0", obs_busy); end
        $display("single job n=10: latency %0d data %0d", cnt, obs_data);
    endtask

    task automatic test_backpressure;
        int  idx = 0, cyc = 0;
        logic done = 1'b0, hs, lst;
        sel8 = 1'b0;
        do_start(1'b1, 6);
        while (!done && cyc < 100) begin
            n_cmp++; if (obs_valid !== 1'b1 || obs_data !== exp_data(idx, 32) || obs_last !== (idx == 6)) begin
                n_err++; $display("FAIL bp_beat[%0d]: got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b", idx, obs_valid, obs_data, obs_last, exp_data(idx, 32), idx == 6);
            end
            ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            start = (cyc % 3 == 1);
            mode  = 1'b0;
            n_in  = 8'd2;
            hs  = obs_valid && ready;
            lst = obs_last;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (hs) begin
                if (lst) done = 1'b1;
                else idx++;
            end
        end
        n_cmp++; if (!done) begin n_err++; $display("FAIL bp_timeout: got idx=%0d want completion", idx); end
        @(posedge clk); #1;
        n_cmp++; if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin n_err++; $display("FAIL bp_start_ignored: got busy=%0b v=%0b want 0", obs_busy, obs_valid); end
        $display("backpressure stream n=6: %0d cycles", cyc);
    endtask

    task automatic test_overflow;
        int cnt;
        sel8 = 1'b0; ready = 1'b1;
        for (int t = 47; t <= 48; t++) begin
            cnt = 0;
            do_start(1'b0, t);
            while (!obs_valid && cnt < 100) begin @(posedge clk); #1; cnt++; end
            n_cmp++; if (obs_valid !== 1'b1 || obs_data !== exp_data(t, 32) || obs_ovf !== exp_ovf(t, 32)) begin
                n_err++; $display("FAIL ovf_n%0d: got v=%0b d=%0d o=%0b want d=%0d o=%0b", t, obs_valid, obs_data, obs_ovf, exp_data(t, 32), exp_ovf(t, 32));
            end
            $display("overflow job n=%0d: data %0d ovf %0b", t, obs_data, obs_ovf);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_small_width;
        sel8 = 1'b1; ready = 1'b1;
        do_start(1'b1, 14);
        for (int i = 0; i <= 14; i++) begin
            n_cmp++; if (obs_valid !== 1'b1 || obs_data !== exp_data(i, 8) || obs_ovf !== exp_ovf(i, 8) || obs_last !== (i == 14)) begin
                n_err++; $display("FAIL w8_beat[%0d]: got d=%0d o=%0b l=%0b want d=%0d o=%0b l=%0b", i, obs_data, obs_ovf, obs_last, exp_data(i, 8), exp_ovf(i, 8), i == 14);
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (obs_busy !== 1'b0) begin n_err++; $display("FAIL w8_end: got busy=%0b want 0", obs_busy); end
        $display("width-8 stream n=14 done");
        sel8 = 1'b0;
    endtask

    task automatic test_edge_index;
        sel8 = 1'b0; ready = 1'b1;
        do_start(1'b0, 0);
        n_cmp++; if (obs_valid !== 1'b0 || obs_busy !== 1'b1) begin n_err++; $display("FAIL n0_single_calc: got v=%0b busy=%0b want v=0 busy=1", obs_valid, obs_busy); end
        @(posedge clk); #1;
        n_cmp++; if (obs_valid !== 1'b1 || obs_data !== 32'd0 || obs_last !== 1'b1) begin n_err++; $display("FAIL n0_single: got v=%0b d=%0d l=%0b want 1 0 1", obs_valid, obs_data, obs_last); end
        @(posedge clk); #1;
        n_cmp++; if (obs_busy !== 1'b0) begin n_err++; $display("FAIL n0_single_end: got busy=%0b want 0", obs_busy); end
        do_start(1'b1, 0);
        n_cmp++; if (obs_valid !== 1'b1 || obs_data !== 32'd0 || obs_last !== 1'b1) begin n_err++; $display("FAIL n0_stream: got v=%0b d=%0d l=%0b want 1 0 1", obs_valid, obs_data, obs_last); end
        @(posedge clk); #1;
        n_cmp++; if (obs_busy !== 1'b0) begin n_err++; $display("FAIL n0_stream_end: got busy=%0b want 0", obs_busy); end
        $display("edge index n=0 single and stream done");
    endtask

    task automatic test_back_to_back;
        sel8 = 1'b0; ready = 1'b1;
        do_start(1'b1, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (obs_busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got busy=%0b want 0", obs_busy); end
        do_start(1'b1, 2);
        for (int i = 0; i <= 2; i++) begin
            n_cmp++; if (obs_valid !== 1'b1 || obs_data !== exp_data(i, 32) || obs_last !== (i == 2)) begin
                n_err++; $display("FAIL b2b_beat[%0d]: got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b", i, obs_valid, obs_data, obs_last, exp_data(i, 32), i == 2);
            end
            @(posedge clk); #1;
        end
        $display("back-to-back jobs done");
    endtask

    task automatic test_random;
        int  idx, cyc, nn, w;
        logic m, done, hs, lst;
        for (int j = 0; j < 16; j++) begin
            sel8 = 1'($urandom_range(0, 1));
            m    = 1'($urandom_range(0, 1));
            nn   = $urandom_range(0, 40);
            w    = sel8 ? 8 : 32;
            do_start(m, nn);
            idx = m ? 0 : nn;
            done = 1'b0; cyc = 0;
            while (!done && cyc < 400) begin
                if (obs_valid) begin
                    n_cmp++; if (obs_data !== exp_data(idx, w) || obs_ovf !== exp_ovf(idx, w) || obs_last !== (!m || idx == nn)) begin
                        n_err++; $display("FAIL rand_j%0d_k%0d: got d=%0d o=%0b l=%0b want d=%0d o=%0b l=%0b", j, idx, obs_data, obs_ovf, obs_last, exp_data(idx, w), exp_ovf(idx, w), !m || idx == nn);
                    end
                end
                ready = 1'($urandom_range(0, 1));
                hs  = obs_valid && ready;
                lst = obs_last;
                @(posedge clk); #1;
                cyc++;
                if (hs) begin
                    if (lst) done = 1'b1;
                    else idx++;
                end
            end
            n_cmp++; if (!done || obs_busy !== 1'b0) begin n_err++; $display("FAIL rand_j%0d_end: got done=%0b busy=%0b want 1 0", j, done, obs_busy); end
            $display("random job %0d: width %0d mode %0b n %0d cycles %0d", j, w, m, nn, cyc);
        end
        sel8 = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_single_latency();
        test_backpressure();
        test_overflow();
        test_small_width();
        test_edge_index();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
